tx_mass_gen: RTL and testbench



---
 rtl/tx_mass_gen.sv | 87 ++++++++
 tb/tb_tx_mass_gen.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/tx_mass_gen.sv
// tx_mass_gen: 6-byte header (mode, fill, 32-bit LE length) then LEN pattern bytes on a 2^OEW-byte stream
module tx_mass_gen #(
  parameter int OEW = 2,
  parameter int PKT_EA = 12
) (
  input  logic                       clk,
  input  logic                       rstn,
  output logic                       i_tready,
  input  logic                       i_tvalid,
  input  logic [7:0]                 i_tdata,
  input  logic                       o_tready,
  output logic                       o_tvalid,
  output logic [8*(1<<OEW)-1:0]      o_tdata,
  output logic [(1<<OEW)-1:0]        o_tkeep,
  output logic                       o_tlast,
  output logic                       o_busy,
  output logic                       o_done
);
  localparam int W = 1 << OEW;
  localparam logic [31:0] PMASK = 32'((64'd1 << PKT_EA) - 64'd1);
  typedef enum logic [1:0] {IDLE, HDR, SEND, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] mode;
  logic [7:0] fill;
  logic [31:0] len, k, rem, nxt;
  logic [2:0] hdr_cnt;
  logic last_beat;
  // remaining-count form keeps LEN=0xFFFFFFFF free of k+n overflow
  assign rem = len - k;
  assign nxt = k + 32'(W);
  assign last_beat = rem <= 32'(W);
  always_comb begin
    state_nx = state;
    i_tready = 1'b0;
    o_tvalid = 1'b0;
    o_tlast = 1'b0;
    o_busy = 1'b0;
    o_done = 1'b0;
    case (state)
      IDLE: begin
        i_tready = rstn;
        if (i_tvalid) state_nx = HDR;
      end
      HDR: begin
        i_tready = rstn;
        o_busy = 1'b1;
        if (i_tvalid && hdr_cnt == 3'd5) state_nx = ({i_tdata, len[31:8]} != 32'd0) ? SEND : DONE;
      end
      SEND: begin
        o_busy = 1'b1;
        o_tvalid = 1'b1;
        o_tlast = last_beat || ((nxt & PMASK) == 32'd0);
        if (o_tready && last_beat) state_nx = DONE;
      end
      default: begin
        o_done = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      mode <= '0;
      fill <= '0;
      len <= '0;
      k <= '0;
      hdr_cnt <= '0;
    end else begin
      state <= state_nx;
      if (i_tready && i_tvalid) begin
        hdr_cnt <= (state == IDLE) ? 3'd1 : hdr_cnt + 3'd1;
        if (state == IDLE) mode <= i_tdata[1:0];
        if (state == HDR && hdr_cnt == 3'd1) fill <= i_tdata;
        if (state == HDR && hdr_cnt >= 3'd2) len <= {i_tdata, len[31:8]};
        if (state == HDR && hdr_cnt == 3'd5) k <= '0;
      end
      if (o_tvalid && o_tready) k <= nxt;
    end
  end
  for (genvar j = 0; j < W; j++) begin : g_lane
    logic [7:0] b;
    assign b = k[7:0] + 8'(j);
    assign o_tkeep[j] = o_tvalid && (rem > 32'(j));
    assign o_tdata[8*j +: 8] = !o_tkeep[j] ? 8'd0 : (mode == 2'd1) ? fill : (mode == 2'd2) ? ~b : b;
  end
endmodule

// File: tb/tb_tx_mass_gen.sv
// tb_tx_mass_gen: two instances (32-bit/8-byte chunks and 8-bit/4096-byte chunks) against a byte-level model
module tb_tx_mass_gen;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  int cur = 0;
  logic in_v = 1'b0;
  logic [7:0] in_d = 8'd0;
  logic rdy = 1'b0;
  int checks = 0;
  int errors = 0;
  logic a_itr, a_tv, a_tl, a_busy, a_done;
  logic [31:0] a_td;
  logic [3:0] a_tk;
  logic b_itr, b_tv, b_tl, b_busy, b_done;
  logic [7:0] b_td;
  logic [0:0] b_tk;
  tx_mass_gen #(.OEW(2), .PKT_EA(3)) u_a (
    .clk(clk), .rstn(rstn), .i_tready(a_itr), .i_tvalid(in_v && cur == 0), .i_tdata(in_d),
    .o_tready(rdy && cur == 0), .o_tvalid(a_tv), .o_tdata(a_td), .o_tkeep(a_tk),
    .o_tlast(a_tl), .o_busy(a_busy), .o_done(a_done));
  tx_mass_gen #(.OEW(0), .PKT_EA(12)) u_b (
    .clk(clk), .rstn(rstn), .i_tready(b_itr), .i_tvalid(in_v && cur == 1), .i_tdata(in_d),
    .o_tready(rdy && cur == 1), .o_tvalid(b_tv), .o_tdata(b_td), .o_tkeep(b_tk),
    .o_tlast(b_tl), .o_busy(b_busy), .o_done(b_done));
  logic itr, tvalid, tlast, busy, done;
  logic [31:0] tdata;
  logic [3:0] tkeep;
  assign itr = cur != 0 ? b_itr : a_itr;
  assign tvalid = cur != 0 ? b_tv : a_tv;
  assign tlast = cur != 0 ? b_tl : a_tl;
  assign busy = cur != 0 ? b_busy : a_busy;
  assign done = cur != 0 ? b_done : a_done;
  assign tdata = cur != 0 ? {24'd0, b_td} : a_td;
  assign tkeep = cur != 0 ? {3'd0, b_tk} : a_tk;
  typedef struct {
    logic [31:0] d;
    logic [3:0] kp;
    logic l;
  } beat_t;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send_hdr(input logic [7:0] mode, input logic [7:0] fill, input logic [31:0] len);
    logic [7:0] h[6];
    h = '{mode, fill, len[7:0], len[15:8], len[23:16], len[31:24]};
    for (int i = 0; i < 6; i++) begin
      in_d = h[i];
      in_v = 1'b1;
      @(negedge clk);
      check("hdr_ready", {31'd0, itr}, 32'd1);
      if (i == 1) check("busy_hdr", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
    end
    in_v = 1'b0;
  endtask
  task automatic xfer(input int s, input logic [7:0] mode, input logic [7:0] fill, input logic [31:0] len, input int rmode);
    beat_t q[$];
    beat_t bt;
    int w, p, cyc, budget;
    logic [7:0] bv;
    w = s != 0 ? 1 : 4;
    p = s != 0 ? 4096 : 8;
    for (longint k = 0; k < len; k += w) begin
      longint n = (len - k < w) ? len - k : w;
      bt.d = '0;
      bt.kp = '0;
      for (int j = 0; j < n; j++) begin
        bv = 8'((k + j) % 256);
        bv = mode[1:0] == 2'd1 ? fill : mode[1:0] == 2'd2 ? ~bv : bv;
        bt.d[8*j +: 8] = bv;
        bt.kp[j] = 1'b1;
      end
      bt.l = ((k + n) % p == 0) || (k + n == len);
      q.push_back(bt);
    end
    cur = s;
    send_hdr(mode, fill, len);
    budget = 4 * int'(len) + 20;
    cyc = 0;
    while (q.size() > 0 && cyc < budget) begin
      rdy = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      @(negedge clk);
      check("valid", {31'd0, tvalid}, 32'd1);
      check("ready_send", {31'd0, itr}, 32'd0);
      check("busy_send", {31'd0, busy}, 32'd1);
      check("tdata", tdata, q[0].d);
      check("tkeep", {28'd0, tkeep}, {28'd0, q[0].kp});
      check("tlast", {31'd0, tlast}, {31'd0, q[0].l});
      @(posedge clk);
      #1;
      if (rdy) void'(q.pop_front());
      cyc++;
    end
    if (q.size() > 0) check("beat_timeout", q.size(), 0);
    rdy = 1'b0;
    @(negedge clk);
    check("done", {31'd0, done}, 32'd1);
    check("busy_done", {31'd0, busy}, 32'd0);
    check("valid_done", {31'd0, tvalid}, 32'd0);
    check("ready_done", {31'd0, itr}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("done_once", {31'd0, done}, 32'd0);
    check("ready_idle", {31'd0, itr}, 32'd1);
    @(posedge clk);
    #1;
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_a"}, {a_itr, a_tv, a_tl, a_busy, a_done, 27'd0} | a_td | {28'd0, a_tk}, 32'd0);
    check({tag, "_b"}, {b_itr, b_tv, b_tl, b_busy, b_done, 27'd0} | {24'd0, b_td} | {31'd0, b_tk}, 32'd0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rstn = 1'b1;
    xfer(0, 8'h00, 8'h5C, 32'd5, 0);
    xfer(0, 8'h01, 8'hA5, 32'd10, 0);
    xfer(0, 8'h02, 8'h00, 32'd8, 1);
    xfer(0, 8'h00, 8'h00, 32'd0, 0);
    xfer(1, 8'h00, 8'h00, 32'd300, 0);
    cur = 0;
    send_hdr(8'h00, 8'h00, 32'd64);
    rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check_zero("mid_reset");
    rstn = 1'b1;
    rdy = 1'b0;
    xfer(0, 8'h00, 8'h00, 32'd4, 0);
    repeat (12) begin
      xfer(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 32'($urandom_range(0, 40)), 2);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
